// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the shared mantissa multiplier issue arbiter.
package mul_arb_pkg;

  localparam int OP_W   = 24;
  localparam int PROD_W = 48;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  // One in-flight slot riding alongside a datapath stage; the tag travels
  // in a parallel array because its width is a parameter of the top.
  typedef struct packed {
    logic    vld;
    req_id_e id;
  } inflight_t;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/mul_rr_arb2.sv
// Two-way round-robin grant with a last-granted pointer.
// Reset points the pointer at REQ1 so REQ0 wins the first tie.
module mul_rr_arb2
  import mul_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       gnt_vld_o,
  output req_id_e    gnt_id_o
);

  req_id_e last_q;
  req_id_e last_d;

  // Grant: a lone requester wins outright; on a tie the one not granted last wins.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_id_o  = REQ0;
    if (en_i) begin
      unique case (req_i)
        2'b01: begin
          gnt_vld_o = 1'b1;
          gnt_id_o  = REQ0;
        end
        2'b10: begin
          gnt_vld_o = 1'b1;
          gnt_id_o  = REQ1;
        end
        2'b11: begin
          gnt_vld_o = 1'b1;
          gnt_id_o  = other_req(last_q);
        end
        default: ;
      endcase
    end
  end

  // Pointer moves only when a grant is actually taken (grant is already gated by en_i).
  always_comb begin
    last_d = last_q;
    if (gnt_vld_o) last_d = gnt_id_o;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= REQ1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mul_issue_arb.sv
// Issue arbiter for one shared 24x24 mantissa multiplier: round-robin grant
// between two requesters, registered operand issue, a MUL_LAT-deep tracker
// aligned with the external datapath stages, and a one-entry response register.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and their operands stable until ready;
// reqN_ready is combinational. rsp_* stay stable while rsp_valid=1 and
// rsp_ready=0. The whole pipe (issue, tracker, datapath via mul_en) advances
// only when the response register is empty or being drained this cycle.
module mul_issue_arb
  import mul_arb_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  output logic              mul_en,
  input  logic [PROD_W-1:0] mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [PROD_W-1:0] rsp_p,
  output logic              idle
);

  logic              adv;
  logic              gnt_vld;
  req_id_e           gnt_id;
  logic [OP_W-1:0]   sel_a;
  logic [OP_W-1:0]   sel_b;
  logic [TAG_W-1:0]  sel_tag;

  logic              issue_vld_q;
  req_id_e           issue_id_q;
  logic [TAG_W-1:0]  issue_tag_q;
  logic [OP_W-1:0]   mul_a_q;
  logic [OP_W-1:0]   mul_b_q;

  inflight_t         last_ent;
  logic [TAG_W-1:0]  last_tag;
  logic              trk_any;

  logic              rsp_valid_q;
  req_id_e           rsp_id_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [PROD_W-1:0] rsp_p_q;

  // Reset is folded in so nothing is granted or advanced while rst_n is low.
  assign adv    = rst_n & (~rsp_valid_q | rsp_ready);
  assign mul_en = adv;

  mul_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (adv),
    .req_i     ({req1_valid, req0_valid}),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  assign req0_ready = gnt_vld & (gnt_id == REQ0);
  assign req1_ready = gnt_vld & (gnt_id == REQ1);

  // Steer the granted requester's operation toward the issue stage.
  always_comb begin
    sel_a   = req0_a;
    sel_b   = req0_b;
    sel_tag = req0_tag;
    if (gnt_id == REQ1) begin
      sel_a   = req1_a;
      sel_b   = req1_b;
      sel_tag = req1_tag;
    end
  end

  // Issue stage: capture on accept; a bubble keeps the old operands so the
  // multiplier inputs do not toggle for nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_vld_q <= 1'b0;
      issue_id_q  <= REQ0;
      issue_tag_q <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else if (adv) begin
      issue_vld_q <= gnt_vld;
      if (gnt_vld) begin
        issue_id_q  <= gnt_id;
        issue_tag_q <= sel_tag;
        mul_a_q     <= sel_a;
        mul_b_q     <= sel_b;
      end
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  if (MUL_LAT > 0) begin : g_trk
    inflight_t        trk_q     [MUL_LAT];
    logic [TAG_W-1:0] trk_tag_q [MUL_LAT];

    // Tracker shift register, one slot per datapath register stage.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < MUL_LAT; i++) begin
          trk_q[i]     <= '0;
          trk_tag_q[i] <= '0;
        end
      end else if (adv) begin
        trk_q[0]     <= '{vld: issue_vld_q, id: issue_id_q};
        trk_tag_q[0] <= issue_tag_q;
        for (int i = 1; i < MUL_LAT; i++) begin
          trk_q[i]     <= trk_q[i-1];
          trk_tag_q[i] <= trk_tag_q[i-1];
        end
      end
    end

    // Any live slot in the tracker keeps the block busy.
    always_comb begin
      trk_any = 1'b0;
      for (int i = 0; i < MUL_LAT; i++) trk_any = trk_any | trk_q[i].vld;
    end

    assign last_ent = trk_q[MUL_LAT-1];
    assign last_tag = trk_tag_q[MUL_LAT-1];
  end else begin : g_no_trk
    // Combinational multiplier: the issue stage lines up with mul_p directly.
    assign last_ent = '{vld: issue_vld_q, id: issue_id_q};
    assign last_tag = issue_tag_q;
    assign trk_any  = 1'b0;
  end

  // Response register: loads the tracker tail and the product on every advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ0;
      rsp_tag_q   <= '0;
      rsp_p_q     <= '0;
    end else if (adv) begin
      rsp_valid_q <= last_ent.vld;
      rsp_id_q    <= last_ent.id;
      rsp_tag_q   <= last_tag;
      rsp_p_q     <= mul_p;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_p     = rsp_p_q;
  assign idle      = ~(issue_vld_q | trk_any | rsp_valid_q);

endmodule

// File: tb/tb_mul_issue_arb.sv
// Bench for mul_issue_arb: behavioural multiplier datapath, per-requester
// op queues, a scoreboard of expected responses, and a negedge monitor.
module tb_mul_issue_arb;

  localparam int LAT = 2;
  localparam int TW  = 4;
  localparam int EW  = 1 + TW + 48;
  localparam int DPN = (LAT > 0) ? LAT : 1;

  typedef struct {
    logic [23:0]   a;
    logic [23:0]   b;
    logic [TW-1:0] tag;
  } op_t;

  // Clock/reset and DUT signals
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [TW-1:0] req0_tag = '0, req1_tag = '0;
  logic          req0_ready, req1_ready;
  logic [23:0]   mul_a, mul_b;
  logic          mul_en;
  logic [47:0]   mul_p;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_id;
  logic [TW-1:0] rsp_tag;
  logic [47:0]   rsp_p;
  logic          idle;

  always #5 clk = ~clk;

  mul_issue_arb #(.MUL_LAT(LAT), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_tag   (req1_tag),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_en     (mul_en),
    .mul_p      (mul_p),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag),
    .rsp_p      (rsp_p),
    .idle       (idle)
  );

  // External multiplier: LAT enabled register stages
  logic [47:0] dp_q [DPN];
  initial for (int i = 0; i < DPN; i++) dp_q[i] = '0;
  always @(posedge clk) begin
    if (mul_en) begin
      dp_q[0] <= 48'(mul_a) * 48'(mul_b);
      for (int i = 1; i < DPN; i++) dp_q[i] <= dp_q[i-1];
    end
  end
  assign mul_p = (LAT == 0) ? 48'(mul_a) * 48'(mul_b) : dp_q[DPN-1];

  // Counters and scoreboard
  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] exp_q[$];
  int            stamp_q[$];
  op_t           pend0[$];
  op_t           pend1[$];
  bit            acc0 = 0, acc1 = 0;
  int            gap_pct = 0;
  bit            rdy_mode = 0;
  int            rsp_vis_cnt = 0;
  logic [47:0]   last_rsp_p = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.a   = 24'($urandom());
    o.b   = 24'($urandom());
    o.tag = TW'($urandom_range(15));
    if ($urandom_range(9) == 0) o.a = 24'hFFFFFF;
    if ($urandom_range(9) == 1) o.b = 24'h000000;
    return o;
  endfunction

  // Driver: each requester presents the head of its queue, holds it until accepted
  always @(posedge clk) begin
    #1;
    if (acc0) begin
      if (pend0.size() > 0) void'(pend0.pop_front());
      acc0 = 0;
      req0_valid = 1'b0;
    end
    if (acc1) begin
      if (pend1.size() > 0) void'(pend1.pop_front());
      acc1 = 0;
      req1_valid = 1'b0;
    end
    if (!req0_valid && pend0.size() > 0 && $urandom_range(99) >= gap_pct) begin
      req0_valid = 1'b1;
      req0_a = pend0[0].a; req0_b = pend0[0].b; req0_tag = pend0[0].tag;
    end
    if (!req1_valid && pend1.size() > 0 && $urandom_range(99) >= gap_pct) begin
      req1_valid = 1'b1;
      req1_a = pend1[0].a; req1_b = pend1[0].b; req1_tag = pend1[0].tag;
    end
    if (rdy_mode) rsp_ready = ($urandom_range(99) < 70);
  end

  // Monitor: reference arbitration, pipeline occupancy, latency and ordering
  int            model_last = 1;
  int            adv_cnt = 0;
  bit            prev_stall = 0;
  bit            head_seen = 0;
  logic [EW-1:0] held;
  logic [EW-1:0] e;
  logic          adv_m;
  logic [1:0]    g_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stamp_q.delete();
      model_last = 1;
      prev_stall = 0;
      head_seen  = 0;
    end else begin
      adv_m = !rsp_valid || rsp_ready;
      chk("mul_en", mul_en, adv_m);
      chk("idle", idle, exp_q.size() == 0);
      g_exp = 2'b00;
      if (adv_m) begin
        if (req0_valid && req1_valid) g_exp = (model_last == 0) ? 2'b10 : 2'b01;
        else if (req0_valid)          g_exp = 2'b01;
        else if (req1_valid)          g_exp = 2'b10;
      end
      chk("grant", {req1_ready, req0_ready}, g_exp);
      if (prev_stall) chk("rsp_hold", {rsp_valid, rsp_id, rsp_tag, rsp_p}, {1'b1, held});
      if (rsp_valid) begin
        rsp_vis_cnt++;
        chk("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0 && !head_seen) begin
          head_seen = 1;
          chk("latency", adv_cnt - stamp_q[0], LAT + 1);
        end
        if (rsp_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          void'(stamp_q.pop_front());
          head_seen = 0;
          last_rsp_p = rsp_p;
          chk("rsp_id", rsp_id, e[EW-1]);
          chk("rsp_tag", rsp_tag, e[EW-2 -: TW]);
          chk("rsp_p", rsp_p, e[47:0]);
        end
      end
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, req0_tag, 48'(req0_a) * 48'(req0_b)});
        stamp_q.push_back(adv_cnt + 1);
        model_last = 0;
        acc0 = 1;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, req1_tag, 48'(req1_a) * 48'(req1_b)});
        stamp_q.push_back(adv_cnt + 1);
        model_last = 1;
        acc1 = 1;
      end
      prev_stall = rsp_valid && !rsp_ready;
      held = {rsp_id, rsp_tag, rsp_p};
      if (adv_m) adv_cnt++;
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || exp_q.size() != 0 || !idle) && n < budget) begin
      @(posedge clk); #3;
      n++;
    end
    chk("drain", (pend0.size() == 0 && pend1.size() == 0 && exp_q.size() == 0 && idle), 1);
  endtask

  task automatic check_reset_state();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_p", rsp_p, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_mul_en", mul_en, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_idle", idle, 1);
  endtask

  // Main sequence
  initial begin
    int vis_before;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_reset_state();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Single op, smallest case
    pend0.push_back('{24'd3, 24'd5, 4'd1});
    wait_drain(50);
    chk("single_p", last_rsp_p, 48'd15);

    // Largest operands
    pend1.push_back('{24'hFFFFFF, 24'hFFFFFF, 4'd2});
    wait_drain(50);
    chk("max_p", last_rsp_p, 48'hFFFFFE000001);

    // Contention: both requesters full rate
    for (int i = 0; i < 8; i++) begin
      pend0.push_back('{24'(i + 1), 24'(100 + i), 4'(i)});
      pend1.push_back('{24'(200 + i), 24'(7 * i + 3), 4'(8 + i)});
    end
    wait_drain(200);

    // Backpressure mid-stream
    for (int i = 0; i < 10; i++) begin
      pend0.push_back(rand_op());
      pend1.push_back(rand_op());
    end
    repeat (6) @(posedge clk);
    #2;
    rsp_ready = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    wait_drain(300);

    // Randomised traffic with random gaps and random consumer stalls
    gap_pct = 30;
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      pend0.push_back(rand_op());
      pend1.push_back(rand_op());
    end
    wait_drain(3000);
    rdy_mode = 0;
    gap_pct = 0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;

    // Reset with three ops in flight
    for (int i = 0; i < 6; i++) begin
      pend0.push_back(rand_op());
      pend1.push_back(rand_op());
    end
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    pend0.delete();
    pend1.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #2;
    check_reset_state();
    rst_n = 1'b1;
    vis_before = rsp_vis_cnt;
    repeat (10) @(posedge clk);
    #2;
    chk("no_stale_rsp", rsp_vis_cnt - vis_before, 0);

    // Arbitration restarts with requester 0 after reset
    for (int i = 0; i < 2; i++) begin
      pend0.push_back(rand_op());
      pend1.push_back(rand_op());
    end
    wait_drain(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
